// File: rtl/store_queue.sv
// Store queue: checks store alignment, builds replicated write data and byte
// strobes, buffers entries in a FIFO, and drains them over an SRAM req/ack port.
module store_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [1:0]                st_size,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  output logic                      st_exc,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W/8-1:0]       mem_wen,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_hazard,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int WA = ADDR_W - LB;

  typedef struct packed {
    logic [WA-1:0]     waddr;
    logic [NB-1:0]     wen;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t                 q [DEPTH];
  entry_t                 in_e;
  entry_t                 head;
  logic [DEPTH-1:0]       vld;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [2:0]             size_mask;
  logic                   illegal, misalign, push, pop;
  logic [NB-1:0][7:0]     sd, rep;
  logic [NB-1:0]          wen_in;
  logic [LB-1:0]          off;

  // size_mask = bytes-1 for the access; 3'b111 for a double
  assign size_mask = (3'd1 << st_size) - 3'd1;
  assign illegal   = (DATA_W == 32) && (st_size == 2'd3);
  assign misalign  = |(st_addr[2:0] & size_mask);
  assign st_exc    = st_valid & (illegal | misalign);
  assign st_ready  = (count != DEPTH[PW:0]);
  assign push      = st_valid & st_ready & ~st_exc;
  assign pop       = mem_req & mem_ack;
  assign off       = st_addr[LB-1:0];
  assign sd        = st_data;

  // Each lane takes the source byte at its offset within the access size, and
  // strobes on when it sits in the same size-aligned block as the address.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [LB-1:0] src;
    assign src       = LB'(i) & size_mask[LB-1:0];
    assign rep[i]    = sd[src];
    assign wen_in[i] = ((LB'(i) ^ off) & ~size_mask[LB-1:0]) == '0;
  end

  assign in_e = '{waddr: st_addr[ADDR_W-1:LB], wen: wen_in, wdata: rep};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: only entries with vld set are ever observed.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= in_e;
  end

  assign empty     = (count == '0);
  assign mem_req   = ~empty;
  assign head      = q[rd_ptr];
  assign mem_addr  = {head.waddr, {LB{1'b0}}};
  assign mem_wen   = head.wen;
  assign mem_wdata = head.wdata;

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && (q[i].waddr == ld_addr[ADDR_W-1:LB])) ld_hazard = 1'b1;
  end
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: one 32-bit and one 64-bit instance share
// stimulus buses, with per-instance valid/ack so each can be driven alone.
module tb_store_queue;
  logic        clk = 1'b0, rst = 1'b1;
  logic        v32 = 1'b0, v64 = 1'b0, a32 = 1'b0, a64 = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, ld = '0;
  logic [63:0] data = '0;

  logic        rdy32, exc32, req32, hz32, emp32;
  logic [31:0] maddr32, wd32;
  logic [3:0]  wen32;
  logic [2:0]  cnt32;
  logic        rdy64, exc64, req64, hz64, emp64;
  logic [31:0] maddr64;
  logic [63:0] wd64;
  logic [7:0]  wen64;
  logic [2:0]  cnt64;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  store_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) u32 (
    .clk(clk), .rst(rst), .st_valid(v32), .st_ready(rdy32), .st_size(size),
    .st_addr(addr), .st_data(data[31:0]), .st_exc(exc32), .mem_req(req32),
    .mem_addr(maddr32), .mem_wen(wen32), .mem_wdata(wd32), .mem_ack(a32),
    .ld_addr(ld), .ld_hazard(hz32), .empty(emp32), .count(cnt32));

  store_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) u64 (
    .clk(clk), .rst(rst), .st_valid(v64), .st_ready(rdy64), .st_size(size),
    .st_addr(addr), .st_data(data), .st_exc(exc64), .mem_req(req64),
    .mem_addr(maddr64), .mem_wen(wen64), .mem_wdata(wd64), .mem_ack(a64),
    .ld_addr(ld), .ld_hazard(hz64), .empty(emp64), .count(cnt64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input bit p32, input bit p64, input logic [1:0] sz,
                      input logic [31:0] ad, input logic [63:0] d);
    v32 = p32; v64 = p64; size = sz; addr = ad; data = d;
    step();
    v32 = 1'b0; v64 = 1'b0;
  endtask

  task automatic ack(input bit k32, input bit k64);
    a32 = k32; a64 = k64;
    step();
    a32 = 1'b0; a64 = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_count32", cnt32, 0);
    chk("rst_empty32", emp32, 1);
    chk("rst_ready32", rdy32, 1);
    chk("rst_req32", req32, 0);
    chk("rst_hz32", hz32, 0);
    chk("rst_req64", req64, 0);
    rst = 1'b0;
    step();

    // replication and strobes
    push(1, 1, 2'd0, 32'h1003, 64'hA5);
    chk("sb_wen32", wen32, 4'b1000);
    chk("sb_wd32", wd32, 32'hA5A5A5A5);
    chk("sb_addr32", maddr32, 32'h1000);
    chk("sb_cnt32", cnt32, 1);
    chk("sb_wen64", wen64, 8'h08);
    chk("sb_wd64", wd64, 64'hA5A5A5A5A5A5A5A5);
    ack(1, 1);
    chk("sb_empty32", emp32, 1);
    chk("sb_empty64", emp64, 1);

    push(1, 1, 2'd1, 32'h1002, 64'h1234);
    chk("sh_wen32", wen32, 4'b1100);
    chk("sh_wd32", wd32, 32'h12341234);
    chk("sh_wen64", wen64, 8'h0C);
    chk("sh_wd64", wd64, 64'h1234123412341234);
    ack(1, 1);

    push(1, 1, 2'd2, 32'h1000, 64'hDEADBEEF);
    chk("sw_wen32", wen32, 4'b1111);
    chk("sw_addr32", maddr32, 32'h1000);
    chk("sw_wd32", wd32, 32'hDEADBEEF);
    chk("sw_wen64", wen64, 8'h0F);
    chk("sw_wd64", wd64, 64'hDEADBEEFDEADBEEF);
    ack(1, 1);

    push(0, 1, 2'd0, 32'h1005, 64'hA5);
    chk("sb5_wen64", wen64, 8'b00100000);
    chk("sb5_addr64", maddr64, 32'h1000);
    ack(0, 1);
    push(0, 1, 2'd3, 32'h1008, 64'h0123456789ABCDEF);
    chk("sd_wen64", wen64, 8'hFF);
    chk("sd_addr64", maddr64, 32'h1008);
    chk("sd_wd64", wd64, 64'h0123456789ABCDEF);
    ack(0, 1);
    push(0, 1, 2'd1, 32'h1006, 64'h1234);
    chk("sh6_wen64", wen64, 8'hC0);
    ack(0, 1);

    // misalignment
    v32 = 1; v64 = 1; size = 2'd1; addr = 32'h1001; #1;
    chk("mis_sh32", exc32, 1);
    chk("mis_sh64", exc64, 1);
    step();
    chk("mis_cnt32", cnt32, 0);
    chk("mis_cnt64", cnt64, 0);
    size = 2'd2; addr = 32'h1002; #1;
    chk("mis_sw32", exc32, 1);
    chk("mis_sw64", exc64, 1);
    size = 2'd3; addr = 32'h1004; #1;
    chk("mis_sd64", exc64, 1);
    addr = 32'h1000; #1;
    chk("sd_illegal32", exc32, 1);
    chk("sd_ok64", exc64, 0);
    v64 = 0;
    step();
    chk("ill_cnt32", cnt32, 0);
    v32 = 0; addr = 32'h1001; size = 2'd1; #1;
    chk("exc_novalid32", exc32, 0);

    // fill to DEPTH with no ack
    for (int i = 0; i < 4; i++) begin
      push(1, 1, 2'd2, 32'h3000 + 32'(4 * i), 64'(32'h100 + 32'(i)));
      if (i == 2) chk("ready_3", rdy32, 1);
    end
    chk("full_ready32", rdy32, 0);
    chk("full_cnt32", cnt32, 4);
    chk("full_ready64", rdy64, 0);
    push(1, 1, 2'd2, 32'h3010, 64'h104);
    chk("ovf_cnt32", cnt32, 4);
    v32 = 1; v64 = 1; addr = 32'h3020; a32 = 1; a64 = 1;
    step();
    v32 = 0; v64 = 0; a32 = 0; a64 = 0;
    chk("full_ack_cnt32", cnt32, 3);
    chk("full_ack_cnt64", cnt64, 3);
    chk("head_addr32", maddr32, 32'h3004);
    chk("head_addr64", maddr64, 32'h3000);
    chk("head_wen64", wen64, 8'hF0);
    chk("head_wd64", wd64, 64'h0000010100000101);

    // stall stability, then back-to-back drain
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr32", maddr32, 32'h3004);
      chk("stall_wd32", wd32, 32'h101);
      chk("stall_req32", req32, 1);
    end
    a32 = 1; a64 = 1;
    step();
    chk("drain1_addr", maddr32, 32'h3008);
    chk("drain1_wd", wd32, 32'h102);
    chk("drain1_cnt", cnt32, 2);
    step();
    chk("drain2_addr", maddr32, 32'h300C);
    chk("drain2_wd", wd32, 32'h103);
    step();
    a32 = 0; a64 = 0;
    chk("drain_empty32", emp32, 1);
    chk("drain_req32", req32, 0);
    chk("drain_empty64", emp64, 1);

    // load hazard
    push(1, 1, 2'd2, 32'h2004, 64'h55);
    ld = 32'h2006; #1;
    chk("hz_hit32", hz32, 1);
    chk("hz_hit64", hz64, 1);
    ld = 32'h2008; #1;
    chk("hz_miss32", hz32, 0);
    chk("hz_miss64", hz64, 0);
    ld = 32'h2000; #1;
    chk("hz_lo32", hz32, 0);
    chk("hz_lo64", hz64, 1);
    ld = 32'h2006; a32 = 1; a64 = 1; #1;
    chk("hz_retiring32", hz32, 1);
    step();
    a32 = 0; a64 = 0;
    chk("hz_gone32", hz32, 0);
    chk("hz_gone64", hz64, 0);

    // asynchronous reset mid-drain
    push(1, 1, 2'd2, 32'h4000, 64'h1);
    push(1, 1, 2'd2, 32'h4004, 64'h2);
    chk("pre_rst_req32", req32, 1);
    chk("pre_rst_cnt32", cnt32, 2);
    #3 rst = 1'b1; #1;
    chk("arst_req32", req32, 0);
    chk("arst_cnt32", cnt32, 0);
    chk("arst_empty32", emp32, 1);
    chk("arst_req64", req64, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_cnt32", cnt32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
